// File: rtl/uart_ack_sequencer.sv
// Buffers nibbles from the UART receiver and answers each one with an
// ACK byte {ACK_PREFIX, nibble} over the transmitter's start/busy handshake.
module uart_ack_sequencer #(
  parameter int         DEPTH        = 4,
  parameter logic [3:0] ACK_PREFIX   = 4'hA,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     cs,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [3:0]               led,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     tx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam int TL = BUSY_TIMEOUT - 1;
  localparam logic [AW:0]   FULL     = DEPTH[AW:0];
  localparam logic [TW-1:0] TMO_LAST = TL[TW-1:0];

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] WAIT_LO = 2'd2;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic          accept;
  logic          pop;
  logic          push;

  // A full FIFO can still take a nibble when the head leaves in the same cycle.
  assign accept = rx_done && !cs;
  assign pop    = (state == IDLE) && (fifo_count != '0) && !cs && !tx_busy;
  assign push   = accept && ((fifo_count != FULL) || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      led        <= '0;
      overflow   <= 1'b0;
      tx_timeout <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      state      <= IDLE;
      tmo_cnt    <= '0;
    end else begin
      tx_start <= 1'b0;

      if (accept) begin
        led <= rx_data;
      end
      if (accept && !push) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end

      // A byte whose busy never arrives is dropped rather than retried.
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= {ACK_PREFIX, mem[rd_ptr]};
            tx_start <= 1'b1;
            tmo_cnt  <= '0;
            state    <= ARM;
          end
        end
        ARM: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            tx_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ack_sequencer.sv
// Drives the ACK sequencer with directed and random traffic against a
// queue-based reference model and an adjustable transmitter model.
module tb_uart_ack_sequencer;

  localparam int DEPTH        = 4;
  localparam int BUSY_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       cs = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [3:0] led;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       tx_timeout;

  uart_ack_sequencer #(
    .DEPTH(DEPTH), .ACK_PREFIX(4'hA), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .cs(cs),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .led(led),
    .fifo_count(fifo_count), .overflow(overflow), .tx_timeout(tx_timeout)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of pending nibbles plus the handshake progress.
  logic [3:0] q[$];
  logic [3:0] m_led = '0;
  logic       m_ovf = 1'b0;
  logic       m_tmo = 1'b0;
  logic       m_start = 1'b0;
  logic [7:0] m_data = '0;
  bit         in_flight = 0;
  bit         busy_seen = 0;
  int         arm_cycles = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_led = '0; m_ovf = 1'b0; m_tmo = 1'b0; m_start = 1'b0; m_data = '0;
      in_flight = 0; busy_seen = 0; arm_cycles = 0;
    end else begin
      m_start = 1'b0;
      if (in_flight) begin
        if (!busy_seen) begin
          if (tx_busy) busy_seen = 1;
          else begin
            arm_cycles++;
            if (arm_cycles == BUSY_TIMEOUT) begin
              m_tmo = 1'b1;
              in_flight = 0;
            end
          end
        end else if (!tx_busy) begin
          in_flight = 0;
        end
      end else if (q.size() > 0 && !cs && !tx_busy) begin
        m_data = {4'hA, q.pop_front()};
        m_start = 1'b1;
        in_flight = 1;
        busy_seen = 0;
        arm_cycles = 0;
      end
      if (rx_done && !cs) begin
        m_led = rx_data;
        if (q.size() < DEPTH) q.push_back(rx_data);
        else m_ovf = 1'b1;
      end
    end
  end

  // Transmitter model modes: 0 normal, 1 stuck busy, 2 dead, 3 busy latches on start.
  int tx_mode = 0;
  int pend_lat = 0;
  int pend_len = 0;
  int tx_len_lo = 1;
  int tx_len_hi = 6;
  int n_starts = 0;
  logic [7:0] sent[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic done, input logic [3:0] data, input logic csv);
    @(negedge clk);
    checkOutput("led", led, m_led);
    checkOutput("fifo_count", fifo_count, q.size());
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("tx_timeout", tx_timeout, m_tmo);
    checkOutput("tx_start", tx_start, m_start);
    checkOutput("tx_data", tx_data, m_data);
    if (tx_start) begin
      n_starts++;
      sent.push_back(tx_data);
    end
    case (tx_mode)
      0: begin
        if (tx_start) begin
          pend_lat = $urandom_range(0, 2);
          pend_len = $urandom_range(tx_len_lo, tx_len_hi);
        end
        if (pend_lat > 0) begin
          pend_lat--;
          tx_busy = 1'b0;
        end else if (pend_len > 0) begin
          pend_len--;
          tx_busy = 1'b1;
        end else tx_busy = 1'b0;
      end
      1: tx_busy = 1'b1;
      2: tx_busy = 1'b0;
      default: if (tx_start) tx_busy = 1'b1;
    endcase
    rx_done = done;
    rx_data = data;
    cs = csv;
  endtask

  task automatic idle(input int n, input logic csv);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, csv);
  endtask

  int base;
  int starts0;
  logic [7:0] exp_b[5];

  initial begin
    $display("[TB] start");
    idle(3, 1'b0);
    reset = 1'b1;
    idle(2, 1'b0);

    // Single nibble, transmitter busy for 10 cycles.
    tx_len_lo = 10; tx_len_hi = 10;
    base = sent.size();
    applyStimulus(1'b1, 4'h5, 1'b0);
    idle(25, 1'b0);
    checkOutput("single_led", led, 4'h5);
    checkOutput("single_count", fifo_count, 0);
    checkOutput("single_nstart", sent.size() - base, 1);
    checkOutput("single_byte", sent[base], 8'hA5);

    // Burst while the transmitter stays busy.
    tx_len_lo = 1; tx_len_hi = 6;
    tx_mode = 1;
    base = sent.size();
    applyStimulus(1'b1, 4'h3, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b0);
    applyStimulus(1'b1, 4'hC, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("burst_count", fifo_count, 3);
    tx_mode = 0;
    idle(60, 1'b0);
    checkOutput("burst_nstart", sent.size() - base, 3);
    checkOutput("burst_b0", sent[base], 8'hA3);
    checkOutput("burst_b1", sent[base+1], 8'hA7);
    checkOutput("burst_b2", sent[base+2], 8'hAC);

    // Overflow: first byte launches, then the transmitter stalls.
    tx_mode = 3;
    base = sent.size();
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 4'(i), 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_led", led, 4'h6);
    checkOutput("ovf_count", fifo_count, 4);
    tx_mode = 0;
    idle(80, 1'b0);
    exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    checkOutput("ovf_nstart", sent.size() - base, 5);
    for (int i = 0; i < 5; i++) checkOutput("ovf_byte", sent[base+i], exp_b[i]);

    // cs gating of both accept and launch.
    tx_mode = 1;
    base = sent.size();
    applyStimulus(1'b1, 4'h8, 1'b0);
    applyStimulus(1'b1, 4'hB, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("cs_led", led, 4'hB);
    checkOutput("cs_count", fifo_count, 2);
    tx_mode = 0;
    idle(10, 1'b1);
    checkOutput("cs_blocked", sent.size() - base, 0);
    idle(60, 1'b0);
    checkOutput("cs_nstart", sent.size() - base, 2);
    checkOutput("cs_b0", sent[base], 8'hA8);
    checkOutput("cs_b1", sent[base+1], 8'hAB);

    // Timeout with a dead transmitter, then recovery.
    tx_mode = 2;
    base = sent.size();
    applyStimulus(1'b1, 4'h9, 1'b0);
    idle(25, 1'b0);
    checkOutput("tmo_flag", tx_timeout, 1);
    checkOutput("tmo_byte", sent[base], 8'hA9);
    tx_mode = 0;
    applyStimulus(1'b1, 4'h4, 1'b0);
    idle(30, 1'b0);
    checkOutput("tmo_recover", sent[sent.size()-1], 8'hA4);
    checkOutput("tmo_count", fifo_count, 0);

    // Asynchronous reset while waiting for busy to drop with two queued.
    tx_mode = 3;
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("rst_pre_count", fifo_count, 2);
    #3 reset = 1'b0;
    #1;
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_led", led, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_tmo", tx_timeout, 0);
    checkOutput("rst_data", tx_data, 0);
    checkOutput("rst_start", tx_start, 0);
    #2 reset = 1'b1;
    tx_mode = 0;
    starts0 = n_starts;
    idle(30, 1'b0);
    checkOutput("rst_no_start", n_starts - starts0, 0);

    // Random traffic.
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 5))
        1: tx_mode = 1;
        2: tx_mode = 2;
        3: tx_mode = 3;
        default: tx_mode = 0;
      endcase
      for (int i = 0; i < 80; i++)
        applyStimulus(($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 9) == 0));
    end
    tx_mode = 0;
    idle(60, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_ack_sequencer.md
Name: uart_ack_sequencer

Overview:
Sits between the nibble UART receiver and the byte UART transmitter. Accepts nibbles from the receiver (rx_done pulse, cs low) and buffers them in a small FIFO. For each buffered nibble it sends one ACK byte {ACK_PREFIX, nibble} to the transmitter over a start/busy handshake. Shows the last accepted nibble on LEDs and flags overflow and transmitter stalls.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
ACK_PREFIX, 4'hA, upper nibble of every ACK byte
BUSY_TIMEOUT, 16, cycles allowed for tx_busy to rise after tx_start; at least 2

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
rx_data  in  4  received nibble, valid when rx_done=1
rx_done  in  1  one-cycle pulse from receiver
cs  in  1  chip select from host; high blocks accept and launch
tx_data  out  8  byte to transmitter
tx_start  out  1  one-cycle launch pulse to transmitter
tx_busy  in  1  transmitter busy
led  out  4  last accepted nibble
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; a nibble was dropped because the FIFO was full
tx_timeout  out  1  sticky; tx_busy did not rise within BUSY_TIMEOUT

Behaviour:
- Reset (reset=0, any time, asynchronous): all outputs 0, FIFO empty, pointers 0, FSM in IDLE, timeout counter 0. Any in-flight handshake is abandoned; the FIFO contents are lost.
- Accept:
  - Accept happens when rx_done=1 and cs=0 at a clk edge.
  - On accept, led <= rx_data, whether or not the nibble is stored.
  - If rx_done=1 while cs=1, the nibble is ignored and nothing changes.
- Push:
  - An accepted nibble is written when count<DEPTH.
  - It is also written when count==DEPTH and a pop happens in the same cycle.
  - Otherwise the nibble is dropped and overflow <= 1. overflow clears only on reset.
- Pop: only in IDLE, when count>0, cs=0 and tx_busy=0.
- Count: push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ARM, WAIT_LO.
  - IDLE, pop condition true: pop head; tx_data <= {ACK_PREFIX, head}; tx_start <= 1; go to ARM; clear timeout counter.
  - ARM: tx_start <= 0, so tx_start is high for exactly one cycle.
  - ARM, tx_busy=1: go to WAIT_LO.
  - ARM, otherwise: count up. When the counter reaches BUSY_TIMEOUT, set tx_timeout <= 1 and go to IDLE. The popped byte is discarded, not retried.
  - WAIT_LO, tx_busy=0: go to IDLE.
- tx_data holds its value until the next launch.
- Latency: rx_done sampled at edge N into an empty FIFO with idle TX gives tx_start=1 in the cycle after edge N+1, high for one cycle. With back-to-back traffic, a byte launches at the earliest one cycle after tx_busy falls.
- cs rising while in ARM or WAIT_LO does not abort the handshake. Only new launches are blocked, and FIFO contents are retained until cs falls.
- Bytes are sent in strict FIFO order; none is duplicated.

Test Plan:
- Single nibble: reset, then rx_data=4'h5 with rx_done for 1 cycle, cs=0. Required: led=5; tx_start pulses once with tx_data=8'hA5; tx_busy model high 10 cycles; FSM returns to IDLE; fifo_count=0.
- Burst with slow TX: push 3, 7, C while tx_busy is held high. Required: fifo_count reaches 2–3; bytes A3, A7, AC sent in order; exactly 3 tx_start pulses.
- Overflow with DEPTH=4: push 6 nibbles 1..6 with TX stalled busy. Required: first byte launched; FIFO holds 2–5; nibble 6 dropped; overflow=1; led=6. Then release TX: exactly A1..A5 sent.
- cs gating: rx_done with cs=1 leaves led and count unchanged. FIFO holding 2 entries with cs=1 produces no tx_start; after cs falls both bytes are sent.
- Timeout: tx_busy tied 0 and nibble 9 pushed. Required: tx_start pulse with 8'hA9; tx_timeout=1 after 16 cycles in ARM; FSM in IDLE, accepting and sending new nibbles.
- Async reset mid-transfer: assert reset=0 between edges while in WAIT_LO with 2 entries queued. Required: outputs 0 immediately; fifo_count=0; after release, no tx_start without new input.
